// File: rtl/iot_avg_filter.sv
// iot_avg_filter: block-average filter over non-overlapping windows of 2^LOG2_N samples,
// with valid/ready on both sides, optional round-half-up and synchronous clear.
module iot_avg_filter #(
    parameter int DATA_W = 128,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rnd_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LOG2_N-1:0] fill,
    output logic [15:0]       win_cnt
);
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
    typedef enum logic [1:0] {EMPTY, PEND, STALL} state_t;
    state_t state, state_n;
    logic [ACC_W-1:0] acc, sum, rsum;
    logic [LOG2_N-1:0] fill_n;
    logic accept, fin, consume, valid_n;
    always_comb begin
        out_valid = state != EMPTY;
        in_ready  = !clr && (state != STALL || out_ready);
        accept    = in_valid && in_ready;
        fin       = accept && (&fill);
        consume   = out_valid && out_ready;
        sum       = acc + ACC_W'(in_data);
        rsum      = sum + (rnd_en ? HALF : '0);
        // fill wraps from N-1 back to 0 on the final accept
        fill_n    = clr ? '0 : accept ? fill + LOG2_N'(1) : fill;
        valid_n   = !clr && (fin || (out_valid && !consume));
        state_n   = !valid_n ? EMPTY : (&fill_n) ? STALL : PEND;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            fill     <= '0;
            acc      <= '0;
            out_data <= '0;
            win_cnt  <= '0;
        end else begin
            state   <= state_n;
            fill    <= fill_n;
            acc     <= (clr || fin) ? '0 : accept ? sum : acc;
            win_cnt <= clr ? '0 : fin ? win_cnt + 16'd1 : win_cnt;
            if (fin) out_data <= rsum[ACC_W-1:LOG2_N];
        end
    end
endmodule

// File: doc/iot_avg_filter.md
# iot_avg_filter

Parametrised block-average filter for the IoT data-filtering path. Accepts a stream of unsigned samples over a valid/ready handshake and accumulates non-overlapping windows of N = 2^LOG2_N samples. At the end of each window it emits the window average (truncated or rounded) on a registered valid/ready output. It supersedes the fixed 128-bit, 8-sample averaging function; backpressure, runtime rounding and synchronous clear are new.

## Interface
- DATA_W, 128, sample and result width in bits (≥1)
- LOG2_N, 3, log2 of window length; N = 2^LOG2_N samples per window (1..8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear: drops partial window and any pending result
- rnd_en  in  1  1 = round half up, 0 = truncate; sampled on the window's last accepted sample
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  unsigned sample
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  out_data holds an unconsumed average
- out_data  out  DATA_W  window average, registered
- out_ready  in  1  consumer accepts out_data
- fill  out  LOG2_N  samples accumulated in the current window (0..N-1)
- win_cnt  out  16  completed windows since reset/clr, wraps 0xFFFF→0

## Operation
- Accumulator acc: DATA_W+LOG2_N bits, unsigned, no overflow possible.
- Input accept: in_valid && in_ready && !clr.
- Non-final accept (fill < N-1): acc ← acc + in_data; fill ← fill+1.
- Final accept (fill == N-1): sum = acc + in_data; out_data ← (sum + (rnd_en ? 2^(LOG2_N-1) : 0)) >> LOG2_N; out_valid ← 1; acc ← 0; fill ← 0; win_cnt ← win_cnt+1.
- Rounding never exceeds 2^DATA_W−1; for LOG2_N = 0 there is no rounding term and the output equals the input.
- Output consume: out_valid && out_ready → out_valid ← 0 unless a final accept occurs in the same cycle, in which case the new average loads and out_valid stays 1.
- FSM, derived from out_valid and fill:
  - EMPTY (out_valid=0): in_ready=1.
  - PEND (out_valid=1, fill<N-1): in_ready=1; accumulation of the next window continues.
  - STALL (out_valid=1, fill==N-1): in_ready = out_ready, so the final sample is accepted only when the old result is consumed in the same cycle.
- in_ready is combinational from state, out_ready and clr. It is forced to 0 when clr=1.
- clr has priority over every other event: acc, fill, win_cnt, out_valid ← 0; out_data keeps its value. A sample presented with clr is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, fill=0, win_cnt=0, acc=0.
- Latency: average visible one cycle after the final accept edge.
- Throughput: one sample per cycle. Outputs run at one per N cycles with no stall if out_ready is held high.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- rst mid-window or mid-PEND returns everything to reset values immediately (async), with no output pulse.
- Simultaneous final accept + consume: the old value is consumed, the new value is presented next cycle, and there is no bubble on out_valid.
- rnd_en changes mid-window have no effect until the final accept.
- win_cnt and fill update on the same edge as the accept.

## Test plan
- DATA_W=8, LOG2_N=2, out_ready=1, rnd_en=0. Send 1,2,3,4 → one cycle later out_valid=1, out_data=2, win_cnt=1, fill=0. Repeat with rnd_en=1 → out_data=3.
- All-max: four samples of 255 with rnd_en=1 → out_data=255, no wrap. Four samples of 0 → 0.
- Backpressure: out_ready=0 and 8 samples 10,10,10,10,20,20,20,20 streamed back-to-back. Output holds 10; in_ready drops after the 7th accept (fill=3). Raise out_ready → the 8th sample is accepted the same cycle 10 is consumed, next cycle out_data=20.
- Clear: accept 5,6 (fill=2), assert clr with in_valid=1/data=7 → fill=0, win_cnt=0, in_ready=0 that cycle. Then send 4,4,4,4 → out_data=4.
- Async reset while out_valid=1, fill=2 → all outputs at reset values the same cycle. The next window averages correctly.
- win_cnt wrap: force 65536 windows of zeros → win_cnt returns to 0.
